vga_v_timing_gen: RTL
=====================

// Module: vga_v_timing_gen
// PURPOSE
//  Parametrised vertical timing generator for the VGA pipeline. Counts lines on a
//  per-line tick from the horizontal counter, tracks the vertical phase (active /
//  front porch / sync / back porch) and drives v_sync, v_active, a programmable
//  display window and a frame-start pulse. Window bounds are double-buffered and
//  take effect only at a frame boundary.
// PARAMETERS
//  CNT_W      10   line counter width; must hold V_TOTAL-1 (elaboration error otherwise)
//  V_ACTIVE   480  visible lines
//  V_FRONT    10   front-porch lines
//  V_SYNC     2    sync-pulse lines
//  V_BACK     33   back-porch lines
//  SYNC_POL   0    v_sync asserted level (0 = active-low)
//  WIN_START  100  reset value of window start line (inclusive)
//  WIN_END    300  reset value of window end line (exclusive)
// PORTS
//  clk_25M     in   1      pixel clock; the only clock
//  reset       in   1      asynchronous, active-high reset
//  line_tick   in   1      one-cycle pulse at end of each horizontal line
//  win_load    in   1      strobe: capture win_start_in/win_end_in into pending regs
//  win_start_in in  CNT_W  new window start line
//  win_end_in  in   CNT_W  new window end line
//  v_count     out  CNT_W  current line number, 0..V_TOTAL-1
//  v_phase     out  2      phase_t: ACTIVE / FRONT / SYNC / BACK
//  v_active    out  1      high while v_count < V_ACTIVE
//  v_sync      out  1      sync output, level per SYNC_POL
//  v_window    out  1      high while win_start_q <= v_count < win_end_q
//  frame_start out  1      one-cycle pulse on the cycle v_count becomes 0 by wrap
// BEHAVIOUR
//  - V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK. Phase ranges on v_count:
//    ACTIVE [0,V_ACTIVE-1], FRONT next V_FRONT lines, SYNC next V_SYNC, BACK rest.
//  - Reset: v_count=0, v_phase=ACTIVE, v_active=1, v_sync=~SYNC_POL, frame_start=0,
//    win_start_q/pending=WIN_START, win_end_q/pending=WIN_END,
//    v_window=(WIN_START==0 && WIN_END>0). Reset mid-frame returns to these at once.
//  - On line_tick: v_count<V_TOTAL-1 -> increment; v_count==V_TOTAL-1 -> 0 (wrap).
//    No line_tick -> all state holds. Never counts past V_TOTAL-1.
//  - All outputs registered, updated on the same edge as v_count and decoded from its
//    next value: zero latency between v_count and every flag.
//  - FSM: ACTIVE->FRONT->SYNC->BACK->ACTIVE, each transition on the line_tick that
//    moves v_count into the next range; a zero-length phase (e.g. V_FRONT=0) is skipped.
//  - v_sync = SYNC_POL while v_phase==SYNC, else ~SYNC_POL.
//  - frame_start high exactly one cycle, on the edge of the wrap; not asserted by reset.
//  - win_load: pending regs <= inputs (last load before wrap wins). On wrap,
//    win_*_q <= pending. win_load on the same edge as wrap: new inputs go straight to
//    win_*_q and are used for line 0 of the new frame.
//  - win_start_q >= win_end_q -> v_window never asserted. win_end_q > V_TOTAL allowed;
//    window ends at wrap.
// STRUCTURE
//  - vga_timing_pkg: phase_t enum (ACTIVE,FRONT,SYNC,BACK), 640x480 default timing
//    constants, shared with the horizontal generator.
//  - Sub-module vga_window_shadow: pending/active bound registers with load/commit.
//  - Top holds counter, phase FSM and output decode.
// TESTING
//  1 Reset held 3 cycles, release, 525 line_ticks -> v_count 0..524 then 0,
//    frame_start exactly once at the wrap, v_active low first at line 480.
//  2 Defaults, SYNC_POL=0 -> v_sync low only for lines 490-491, v_phase SYNC there.
//  3 Default window -> v_window high for lines 100..299, low at 99 and 300.
//  4 win_load 50/60 at line 200 -> current frame still 100..299; next frame 50..59.
//  5 win_load 10/20 on the same edge as wrap -> window 10..19 in the new frame;
//    load 30/30 -> v_window never high next frame.
//  6 Assert reset at line 300, line_tick gaps of random length -> outputs equal reset
//    values immediately; counting resumes from 0 with no frame_start pulse.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions.
// Contents:
//   phase_t   - scan phase within a line or frame (ACTIVE / FRONT / SYNC / BACK)
//   *_DEF     - 640x480@60 default timing for the horizontal and vertical generators
//   phase_of  - maps a counter value onto its phase for a given timing
package vga_timing_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;

    // Ranges are tested in scan order, so a zero-length phase has an empty
    // range and can never be returned.
    function automatic phase_t phase_of(input logic [31:0] cnt,
                                        input logic [31:0] len_active,
                                        input logic [31:0] len_front,
                                        input logic [31:0] len_sync);
        phase_t ph;
        if (cnt < len_active) begin
            ph = ACTIVE;
        end else if (cnt < len_active + len_front) begin
            ph = FRONT;
        end else if (cnt < len_active + len_front + len_sync) begin
            ph = SYNC;
        end else begin
            ph = BACK;
        end
        return ph;
    endfunction

endpackage

// File: rtl/vga_window_shadow.sv
// Double-buffered display-window bounds.
// A load strobe captures new bounds into pending registers; the commit strobe
// (frame wrap) copies pending into the active registers. A load on the commit
// edge bypasses pending so the new bounds apply to the first line of the frame.
// Ports:
//   clk_25M, reset          clock, async active-high reset
//   i_load                  capture i_start/i_end into pending
//   i_commit                move pending (or bypassed inputs) into active
//   i_start, i_end          new window bounds
//   o_start_q, o_end_q      active bounds
//   o_start_nxt, o_end_nxt  values the active bounds take on this edge
module vga_window_shadow
    import vga_timing_pkg::*;
#(
    parameter int CNT_W     = 10,
    parameter int WIN_START = 100,
    parameter int WIN_END   = 300
) (
    input  logic             clk_25M,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_commit,
    input  logic [CNT_W-1:0] i_start,
    input  logic [CNT_W-1:0] i_end,
    output logic [CNT_W-1:0] o_start_q,
    output logic [CNT_W-1:0] o_end_q,
    output logic [CNT_W-1:0] o_start_nxt,
    output logic [CNT_W-1:0] o_end_nxt
);

    localparam logic [CNT_W-1:0] L_START_RST = CNT_W'(WIN_START);
    localparam logic [CNT_W-1:0] L_END_RST   = CNT_W'(WIN_END);

    logic [CNT_W-1:0] r_start_pend;
    logic [CNT_W-1:0] r_end_pend;
    logic [CNT_W-1:0] r_start_q;
    logic [CNT_W-1:0] r_end_q;
    logic [CNT_W-1:0] w_start_nxt;
    logic [CNT_W-1:0] w_end_nxt;

    // Next active bounds: unchanged mid-frame, pending or bypassed inputs at commit.
    always_comb begin
        w_start_nxt = r_start_q;
        w_end_nxt   = r_end_q;
        if (i_commit && i_load) begin
            w_start_nxt = i_start;
            w_end_nxt   = i_end;
        end else if (i_commit) begin
            w_start_nxt = r_start_pend;
            w_end_nxt   = r_end_pend;
        end else begin
            w_start_nxt = r_start_q;
            w_end_nxt   = r_end_q;
        end
    end

    // Pending and active bound registers.
    always_ff @(posedge clk_25M or posedge reset) begin
        if (reset) begin
            r_start_pend <= L_START_RST;
            r_end_pend   <= L_END_RST;
            r_start_q    <= L_START_RST;
            r_end_q      <= L_END_RST;
        end else begin
            if (i_load) begin
                r_start_pend <= i_start;
                r_end_pend   <= i_end;
            end
            r_start_q <= w_start_nxt;
            r_end_q   <= w_end_nxt;
        end
    end

    assign o_start_q   = r_start_q;
    assign o_end_q     = r_end_q;
    assign o_start_nxt = w_start_nxt;
    assign o_end_nxt   = w_end_nxt;

endmodule

// File: rtl/vga_v_timing_gen.sv
// Vertical timing generator.
// Counts lines on line_tick, tracks the vertical phase and drives registered
// v_sync / v_active / v_window / frame_start. Every flag is decoded from the
// next line count so it changes on the same edge as v_count.
// Ports:
//   clk_25M                     pixel clock
//   reset                       async active-high reset
//   line_tick                   end-of-line pulse from the horizontal counter
//   win_load, win_start_in,
//   win_end_in                  new window bounds, applied at the next wrap
//   v_count                     line number 0..V_TOTAL-1
//   v_phase                     ACTIVE / FRONT / SYNC / BACK
//   v_active, v_sync, v_window  line flags
//   frame_start                 one-cycle pulse when v_count wraps to 0
module vga_v_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   CNT_W     = 10,
    parameter int   V_ACTIVE  = V_ACTIVE_DEF,
    parameter int   V_FRONT   = V_FRONT_DEF,
    parameter int   V_SYNC    = V_SYNC_DEF,
    parameter int   V_BACK    = V_BACK_DEF,
    parameter logic SYNC_POL  = 1'b0,
    parameter int   WIN_START = 100,
    parameter int   WIN_END   = 300
) (
    input  logic             clk_25M,
    input  logic             reset,
    input  logic             line_tick,
    input  logic             win_load,
    input  logic [CNT_W-1:0] win_start_in,
    input  logic [CNT_W-1:0] win_end_in,
    output logic [CNT_W-1:0] v_count,
    output phase_t           v_phase,
    output logic             v_active,
    output logic             v_sync,
    output logic             v_window,
    output logic             frame_start
);

    localparam int               V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic             L_WIN_RST = (WIN_START == 0) && (WIN_END > 0);

    generate
        if (CNT_W < 32 && (V_TOTAL - 1) >= (1 << CNT_W)) begin : g_cnt_w_too_small
            $error("vga_v_timing_gen: CNT_W cannot hold V_TOTAL-1");
        end
    endgenerate

    logic [CNT_W-1:0] r_count;
    phase_t           r_phase;
    logic             r_active;
    logic             r_sync;
    logic             r_window;
    logic             r_frame_start;

    logic [CNT_W-1:0] w_count_nxt;
    logic [31:0]      w_count_nxt32;
    logic             w_wrap;
    phase_t           w_phase_nxt;
    logic [CNT_W-1:0] w_win_start_q;
    logic [CNT_W-1:0] w_win_end_q;
    logic [CNT_W-1:0] w_win_start_nxt;
    logic [CNT_W-1:0] w_win_end_nxt;

    // Line counter next value; holds when no line_tick arrives.
    always_comb begin
        w_wrap      = 1'b0;
        w_count_nxt = r_count;
        if (line_tick && (r_count >= C_LAST)) begin
            w_wrap      = 1'b1;
            w_count_nxt = '0;
        end else if (line_tick) begin
            w_count_nxt = r_count + 1'b1;
        end else begin
            w_count_nxt = r_count;
        end
    end

    assign w_count_nxt32 = 32'(w_count_nxt);

    // Phase FSM next state: advances only on line_tick, landing on the phase
    // that owns the next line, so zero-length phases fall through.
    always_comb begin
        w_phase_nxt = r_phase;
        case (r_phase)
            ACTIVE, FRONT, SYNC, BACK: begin
                if (line_tick) begin
                    w_phase_nxt = phase_of(w_count_nxt32, 32'(V_ACTIVE),
                                           32'(V_FRONT), 32'(V_SYNC));
                end else begin
                    w_phase_nxt = r_phase;
                end
            end
            default: w_phase_nxt = ACTIVE;
        endcase
    end

    vga_window_shadow #(
        .CNT_W     (CNT_W),
        .WIN_START (WIN_START),
        .WIN_END   (WIN_END)
    ) u_window_shadow (
        .clk_25M     (clk_25M),
        .reset       (reset),
        .i_load      (win_load),
        .i_commit    (w_wrap),
        .i_start     (win_start_in),
        .i_end       (win_end_in),
        .o_start_q   (w_win_start_q),
        .o_end_q     (w_win_end_q),
        .o_start_nxt (w_win_start_nxt),
        .o_end_nxt   (w_win_end_nxt)
    );

    // Counter, phase state and registered output flags.
    always_ff @(posedge clk_25M or posedge reset) begin
        if (reset) begin
            r_count       <= '0;
            r_phase       <= ACTIVE;
            r_active      <= 1'b1;
            r_sync        <= ~SYNC_POL;
            r_window      <= L_WIN_RST;
            r_frame_start <= 1'b0;
        end else begin
            r_count       <= w_count_nxt;
            r_phase       <= w_phase_nxt;
            r_active      <= (w_count_nxt32 < 32'(V_ACTIVE));
            r_sync        <= (w_phase_nxt == SYNC) ? SYNC_POL : ~SYNC_POL;
            // Inverted bounds give an empty range, so no extra guard is needed.
            r_window      <= (w_count_nxt >= w_win_start_nxt) &&
                             (w_count_nxt <  w_win_end_nxt);
            r_frame_start <= w_wrap;
        end
    end

    assign v_count     = r_count;
    assign v_phase     = r_phase;
    assign v_active    = r_active;
    assign v_sync      = r_sync;
    assign v_window    = r_window;
    assign frame_start = r_frame_start;

endmodule
